ifetch_ctrl: RTL
================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch PC loaded on reset.
REQ-002 Parameter ROM_AW, default 14, instruction ROM word-address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en_i  input  1  fetch enable from the core control.
REQ-006 redirect_i  input  1  branch/jump redirect strobe, one cycle.
REQ-007 redirect_pc_i  input  32  redirect target byte address.
REQ-008 rom_addr_o  output  ROM_AW  word address to the combinational instruction ROM.
REQ-009 rom_data_i  input  32  ROM read data, valid in the same cycle as rom_addr_o.
REQ-010 inst_o  output  32  fetched instruction to decode.
REQ-011 pc_o  output  32  byte address of inst_o.
REQ-012 inst_valid_o  output  1  inst_o/pc_o valid.
REQ-013 inst_ready_i  input  1  decode accepts inst_o this cycle.
REQ-014 fault_o  output  1  fetch fault, sticky.

Function
REQ-015 FSM states IDLE, RUN, FAULT; reset state IDLE.
REQ-016 Transitions: IDLE->RUN when en_i=1; RUN->IDLE when en_i=0; RUN->FAULT on fault condition (REQ-027); FAULT exits only through reset.
REQ-017 rom_addr_o SHALL equal fetch_pc[ROM_AW+1:2] combinationally in all states.
REQ-018 Output slot free when inst_valid_o=0 or inst_ready_i=1.
REQ-019 Fetch: in RUN, no redirect, slot free -> inst_o<=rom_data_i, pc_o<=fetch_pc, inst_valid_o<=1, fetch_pc<=fetch_pc+4.
REQ-020 Stall: inst_valid_o=1 and inst_ready_i=0 -> inst_o, pc_o, inst_valid_o and fetch_pc held unchanged.
REQ-021 Drain: slot free and no fetch (IDLE, or RUN with en_i low) -> inst_valid_o<=0.
REQ-022 Redirect has priority over fetch and stall: fetch_pc<=redirect_pc_i, inst_valid_o<=0 on the same edge, regardless of inst_ready_i; accepted in IDLE and RUN, ignored in FAULT.
REQ-023 Latency: redirect in cycle N -> target ROM address driven in N+1 -> target instruction valid in N+2 (RUN, decode ready).
REQ-024 Throughput: one instruction per cycle while RUN and inst_ready_i=1.
REQ-025 fetch_pc+4 wraps modulo 2^32.

Reset
REQ-026 rst_n low -> state IDLE, fetch_pc=RESET_PC, inst_o=0, pc_o=0, inst_valid_o=0, fault_o=0, immediately without clk; mid-stall or mid-redirect reset discards all pending state.

Configuration
REQ-027 Macro IFETCH_FAULT_EN defined: fault when an accepted redirect_pc_i[1:0]!=0 or when a fetch would issue with fetch_pc[31:ROM_AW+2]!=0; next edge state FAULT, fault_o=1, inst_valid_o=0, no further fetch.
REQ-028 Macro IFETCH_FAULT_EN undefined: fault_o tied 0, FAULT state unreachable, redirect_pc_i[1:0] forced to 0, out-of-range PCs alias modulo ROM depth.

Verification
REQ-029 Reset, en_i=1, ready=1, ROM word k = 32'h1000_0000+k -> pc_o 0,4,8,... one per cycle, inst_o matching, first valid two cycles after en_i rises.
REQ-030 Hold inst_ready_i=0 three cycles at pc_o=8 -> inst_o/pc_o/valid stable, no PC skipped after release (next pc_o=12).
REQ-031 Redirect to 32'h0000_0100 during stall -> valid drops next cycle, pc_o=32'h100 valid two cycles after redirect.
REQ-032 Toggle en_i low for two cycles -> valid drains after acceptance, fetch resumes at next sequential PC.
REQ-033 IFETCH_FAULT_EN: redirect to 32'h0000_0102 -> fault_o=1, valid=0 and held until rst_n; without macro, same stimulus -> fetch at 32'h100.
REQ-034 Assert rst_n low mid-stream between clock edges -> all outputs at reset values before the next edge; restart at RESET_PC.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: walks a byte PC through a combinational ROM and
// hands one instruction per cycle to decode. Optional fault checking via IFETCH_FAULT_EN.
module ifetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ROM_AW   = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              redirect_i,
   input  logic [31:0]       redirect_pc_i,
   output logic [ROM_AW-1:0] rom_addr_o,
   input  logic [31:0]       rom_data_i,
   output logic [31:0]       inst_o,
   output logic [31:0]       pc_o,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic              fault_o
);

   typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [31:0] r_fetchPc;
   logic [31:0] r_inst;
   logic [31:0] r_pc;
   logic        r_valid;
   logic        r_fault;

   logic [31:0] w_redirectPc;
   logic        w_slotFree;
   logic        w_redirect;
   logic        w_fetch;
   logic        w_fault;

   assign rom_addr_o   = r_fetchPc[ROM_AW+1:2];
   assign inst_o       = r_inst;
   assign pc_o         = r_pc;
   assign inst_valid_o = r_valid;
   assign fault_o      = r_fault;

   // A redirect always wins; a fetch needs RUN, enable and a free output slot.
   always_comb begin
      w_slotFree = !r_valid || inst_ready_i;
      w_redirect = redirect_i && (r_state != FAULT);
      w_fetch    = (r_state == RUN) && en_i && !w_redirect && w_slotFree;
`ifdef IFETCH_FAULT_EN
      w_redirectPc = redirect_pc_i;
      w_fault      = (w_redirect && (redirect_pc_i[1:0] != 2'b00)) ||
                     (w_fetch && ((r_fetchPc >> (ROM_AW + 2)) != 32'd0));
`else
      w_redirectPc = redirect_pc_i & ~32'h0000_0003;
      w_fault      = 1'b0;
`endif
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (en_i) w_stateNext = RUN;
         RUN:     if (!en_i) w_stateNext = IDLE;
         FAULT:   w_stateNext = FAULT;
         default: w_stateNext = IDLE;
      endcase
      if (w_fault) w_stateNext = FAULT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A fault leaves fetch_pc untouched so the faulting context stays visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetchPc <= RESET_PC;
         r_inst    <= 32'd0;
         r_pc      <= 32'd0;
         r_valid   <= 1'b0;
         r_fault   <= 1'b0;
      end else if (w_fault) begin
         r_fault <= 1'b1;
         r_valid <= 1'b0;
      end else if (w_redirect) begin
         r_fetchPc <= w_redirectPc;
         r_valid   <= 1'b0;
      end else if (r_state == FAULT) begin
         r_valid <= 1'b0;
      end else if (w_fetch) begin
         r_inst    <= rom_data_i;
         r_pc      <= r_fetchPc;
         r_valid   <= 1'b1;
         r_fetchPc <= r_fetchPc + 32'd4;
      end else if (w_slotFree) begin
         r_valid <= 1'b0;
      end
   end

endmodule
